regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_if.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between writeback requesters, the arbiter and the register file write/forward ports.
// REGFILE_WB_PERF_EN adds the per-requester wait counters to the bundle.
interface regfile_wb_arbiter_if #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic                   wb_hold;
   logic                   wb_en;
   logic [ADDR_W-1:0]      wb_addr;
   logic [DATA_W-1:0]      wb_data;
   logic [ADDR_W-1:0]      rd_addr_0;
   logic [ADDR_W-1:0]      rd_addr_1;
   logic                   fwd_hit_0;
   logic                   fwd_hit_1;
   logic [DATA_W-1:0]      fwd_data_0;
   logic [DATA_W-1:0]      fwd_data_1;
   logic                   busy;
`ifdef REGFILE_WB_PERF_EN
   logic [NREQ*32-1:0]     perf_wait_cnt;
`endif

   modport slave (
      input  req_valid, req_addr, req_data, wb_hold, rd_addr_0, rd_addr_1,
      output req_ready, wb_en, wb_addr, wb_data,
      output fwd_hit_0, fwd_hit_1, fwd_data_0, fwd_data_1, busy
`ifdef REGFILE_WB_PERF_EN
      , output perf_wait_cnt
`endif
   );

   modport master (
      output req_valid, req_addr, req_data, wb_hold, rd_addr_0, rd_addr_1,
      input  req_ready, wb_en, wb_addr, wb_data,
      input  fwd_hit_0, fwd_hit_1, fwd_data_0, fwd_data_1, busy
`ifdef REGFILE_WB_PERF_EN
      , input perf_wait_cnt
`endif
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter of NREQ writeback sources onto the single register file write port,
// with one registered stage and read-port forwarding. Optional REGFILE_WB_PERF_EN: wait counters.
module regfile_wb_arbiter #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PTR_W:0]   NREQ_W = (PTR_W+1)'(NREQ);
   localparam logic [PTR_W-1:0] LAST   = PTR_W'(NREQ-1);

   logic                 stg_valid_q, stg_valid_d;
   logic [ADDR_W-1:0]    stg_addr_q,  stg_addr_d;
   logic [DATA_W-1:0]    stg_data_q,  stg_data_d;
   logic [PTR_W-1:0]     rr_ptr_q,    rr_ptr_d;

   logic                 gnt_vld;
   logic [PTR_W-1:0]     gnt_idx;
   logic [NREQ-1:0]      gnt_oh;
   logic [2*NREQ-1:0]    rot;
   logic [PTR_W:0]       sum;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_data;
   logic [NREQ-1:0]      req_ready_w;

   // Rotate the request vector so bit 0 is the current priority holder, then take the first set bit.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      rot     = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
      if (!bus.wb_hold) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!gnt_vld && rot[k]) begin
               gnt_vld = 1'b1;
               sum     = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
               if (sum >= NREQ_W) sum = sum - NREQ_W;
               gnt_idx = sum[PTR_W-1:0];
            end
         end
      end
   end

   always_comb begin
      gnt_oh   = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt_oh[i] = gnt_vld && (gnt_idx == PTR_W'(i));
         if (gnt_oh[i]) begin
            sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Ready is forced low while reset is asserted so no handshake is seen during reset.
   assign req_ready_w = gnt_oh & {NREQ{rst}};

   always_comb begin
      stg_valid_d = stg_valid_q;
      stg_addr_d  = stg_addr_q;
      stg_data_d  = stg_data_q;
      rr_ptr_d    = rr_ptr_q;
      if (!bus.wb_hold) begin
         // A granted write to x0 completes the handshake but leaves the stage empty.
         stg_valid_d = gnt_vld && (sel_addr != '0);
         if (stg_valid_d) begin
            stg_addr_d = sel_addr;
            stg_data_d = sel_data;
         end
         if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_valid_q <= 1'b0;
         stg_addr_q  <= '0;
         stg_data_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         stg_valid_q <= stg_valid_d;
         stg_addr_q  <= stg_addr_d;
         stg_data_q  <= stg_data_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.req_ready  = req_ready_w;
   assign bus.wb_en      = stg_valid_q & ~bus.wb_hold;
   assign bus.wb_addr    = stg_addr_q;
   assign bus.wb_data    = stg_data_q;
   assign bus.busy       = stg_valid_q;

   // Forwarding stays live during hold: the stage still carries the newest value.
   assign bus.fwd_hit_0  = stg_valid_q && (stg_addr_q == bus.rd_addr_0) && (bus.rd_addr_0 != '0);
   assign bus.fwd_hit_1  = stg_valid_q && (stg_addr_q == bus.rd_addr_1) && (bus.rd_addr_1 != '0);
   assign bus.fwd_data_0 = bus.fwd_hit_0 ? stg_data_q : '0;
   assign bus.fwd_data_1 = bus.fwd_hit_1 ? stg_data_q : '0;

`ifdef REGFILE_WB_PERF_EN
   logic [NREQ-1:0][31:0] perf_cnt_q, perf_cnt_d;

   always_comb begin
      perf_cnt_d = perf_cnt_q;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_valid[i] && !req_ready_w[i] && (perf_cnt_q[i] != 32'hFFFF_FFFF))
            perf_cnt_d[i] = perf_cnt_q[i] + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perf_cnt_q <= '0;
      else      perf_cnt_q <= perf_cnt_d;
   end

   assign bus.perf_wait_cnt = perf_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed test-plan sequences with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;
   localparam int NREQ   = 3;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   regfile_wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit              m_vld;
   logic [4:0]      m_addr;
   logic [63:0]     m_data;
   int              m_ptr;
   int unsigned     m_cnt [NREQ];

   function automatic int exp_grant();
      if (!rst || bus.wb_hold) return -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (bus.req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_vld <= 0; m_addr <= '0; m_data <= '0; m_ptr <= 0;
         for (int i = 0; i < NREQ; i++) m_cnt[i] <= 0;
      end else begin
         int g;
         g = exp_grant();
         for (int i = 0; i < NREQ; i++)
            if (bus.req_valid[i] && g != i && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] <= m_cnt[i] + 1;
         if (!bus.wb_hold) begin
            if (g >= 0) begin
               m_ptr <= (g + 1) % NREQ;
               if (bus.req_addr[g*ADDR_W +: ADDR_W] != 0) begin
                  m_vld  <= 1;
                  m_addr <= bus.req_addr[g*ADDR_W +: ADDR_W];
                  m_data <= bus.req_data[g*DATA_W +: DATA_W];
               end else m_vld <= 0;
            end else m_vld <= 0;
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, got, exp, $time);
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      int g;
      logic [NREQ-1:0] rdy;
      bit h0, h1, en;
      g   = exp_grant();
      rdy = '0;
      if (g >= 0) rdy[g] = 1'b1;
      en = m_vld && !bus.wb_hold;
      h0 = m_vld && m_addr == bus.rd_addr_0 && bus.rd_addr_0 != 0;
      h1 = m_vld && m_addr == bus.rd_addr_1 && bus.rd_addr_1 != 0;
      check("m_ready", 64'(bus.req_ready), 64'(rdy));
      check("m_wb_en", 64'(bus.wb_en), 64'(en));
      if (en) begin
         check("m_wb_addr", 64'(bus.wb_addr), 64'(m_addr));
         check("m_wb_data", bus.wb_data, m_data);
      end
      check("m_busy", 64'(bus.busy), 64'(m_vld));
      check("m_hit0", 64'(bus.fwd_hit_0), 64'(h0));
      check("m_hit1", 64'(bus.fwd_hit_1), 64'(h1));
      check("m_fwd0", bus.fwd_data_0, h0 ? m_data : 64'd0);
      check("m_fwd1", bus.fwd_data_1, h1 ? m_data : 64'd0);
`ifdef REGFILE_WB_PERF_EN
      for (int i = 0; i < NREQ; i++)
         check("m_perf", 64'(bus.perf_wait_cnt[i*32 +: 32]), 64'(m_cnt[i]));
`endif
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [4:0] a, input logic [63:0] d);
      for (int i = 0; i < NREQ; i++) begin
         bus.req_addr[i*ADDR_W +: ADDR_W] = a;
         bus.req_data[i*DATA_W +: DATA_W] = d;
      end
   endtask

   logic [NREQ-1:0] rot_exp [6];

   initial begin
      bus.req_valid = 3'b111;   // must not be granted while in reset
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.wb_hold   = 1'b0;
      bus.rd_addr_0 = '0;
      bus.rd_addr_1 = '0;
      repeat (2) step();
      #1;
      check("rst_ready", 64'(bus.req_ready), 64'd0);
      check("rst_wb_en", 64'(bus.wb_en), 64'd0);
      check("rst_busy",  64'(bus.busy), 64'd0);

      // 1: single requester
      step(); rst = 1'b1; bus.req_valid = '0;
      step();
      bus.req_valid = 3'b001;
      bus.req_addr[0 +: ADDR_W] = 5'd5;
      bus.req_data[0 +: DATA_W] = 64'h1234;
      #1 check("t1_ready", 64'(bus.req_ready), 64'b001);
      step(); bus.req_valid = '0;
      #1;
      check("t1_wb_en",   64'(bus.wb_en), 64'd1);
      check("t1_wb_addr", 64'(bus.wb_addr), 64'd5);
      check("t1_wb_data", bus.wb_data, 64'h1234);

      // 2: all valid, strict rotation starting at pointer 1
      rot_exp = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
      set_all(5'd9, 64'hDEAD_0009);
      for (int c = 0; c < 6; c++) begin
         step(); bus.req_valid = 3'b111;
         #1;
         check("t2_grant", 64'(bus.req_ready), 64'(rot_exp[c]));
         if (c > 0) check("t2_wb_en", 64'(bus.wb_en), 64'd1);
      end
      step(); bus.req_valid = '0;
      #1 check("t2_wb_en_last", 64'(bus.wb_en), 64'd1);

      // 3: write to x0 by requester 1 (pointer is 1)
      step();
      bus.req_valid = 3'b010;
      bus.req_addr[1*ADDR_W +: ADDR_W] = 5'd0;
      bus.req_data[1*DATA_W +: DATA_W] = 64'hFF;
      #1 check("t3_ready", 64'(bus.req_ready), 64'b010);
      step(); bus.req_valid = '0;
      #1;
      check("t3_wb_en", 64'(bus.wb_en), 64'd0);
      check("t3_busy",  64'(bus.busy), 64'd0);
      step(); bus.req_valid = 3'b111;
      #1 check("t3_ptr2", 64'(bus.req_ready), 64'b100);

      // 4: hold keeps the stage and its forwarding alive
      step(); set_all(5'd7, 64'hAA);
      for (int c = 0; c < 3; c++) begin
         step(); bus.wb_hold = 1'b1; bus.rd_addr_0 = 5'd7;
         #1;
         check("t4_ready", 64'(bus.req_ready), 64'd0);
         check("t4_wb_en", 64'(bus.wb_en), 64'd0);
         check("t4_busy",  64'(bus.busy), 64'd1);
         check("t4_hit0",  64'(bus.fwd_hit_0), 64'd1);
         check("t4_fwd0",  bus.fwd_data_0, 64'hAA);
      end
      step(); bus.wb_hold = 1'b0; bus.req_valid = '0;
      #1;
      check("t4_rel_en",   64'(bus.wb_en), 64'd1);
      check("t4_rel_addr", 64'(bus.wb_addr), 64'd7);
      step();
      #1 check("t4_once", 64'(bus.wb_en), 64'd0);

      // 5: forwarding hit/miss
      set_all(5'd3, 64'h3333); bus.req_valid = 3'b111;
      step(); bus.req_valid = '0; bus.rd_addr_0 = 5'd3; bus.rd_addr_1 = 5'd4;
      #1;
      check("t5_hit0",  64'(bus.fwd_hit_0), 64'd1);
      check("t5_fwd0",  bus.fwd_data_0, 64'h3333);
      check("t5_hit1",  64'(bus.fwd_hit_1), 64'd0);
      check("t5_fwd1",  bus.fwd_data_1, 64'd0);

      // randomized traffic, checked by the compare process
      for (int c = 0; c < 2000; c++) begin
         step();
         bus.req_valid = NREQ'($urandom);
         bus.wb_hold   = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*ADDR_W +: ADDR_W] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
         end
         bus.rd_addr_0 = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom);
         bus.rd_addr_1 = 5'($urandom);
      end

      // 6: asynchronous reset with a held write in the stage
      step(); bus.wb_hold = 1'b0; bus.req_valid = 3'b111; set_all(5'd9, 64'h99);
      step(); bus.req_valid = '0; bus.wb_hold = 1'b1;
      #1 check("t6_pre_busy", 64'(bus.busy), 64'd1);
      #1 rst = 1'b0;
      #1;
      check("t6_wb_en", 64'(bus.wb_en), 64'd0);
      check("t6_busy",  64'(bus.busy), 64'd0);
`ifdef REGFILE_WB_PERF_EN
      check("t6_perf", 64'(bus.perf_wait_cnt[31:0]), 64'd0);
`endif
      step(); bus.wb_hold = 1'b0;
      step(); rst = 1'b1;
      step();
      #1 check("t6_after", 64'(bus.wb_en), 64'd0);
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
